binary_to_bcd: RTL and testbench

BINARY_TO_BCD -- requirements
Module: binary_to_bcd

---
 rtl/binary_to_bcd.sv | 109 ++++++++++
 tb/tb_binary_to_bcd.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd.sv
// Sequential 26-bit binary to 8-digit BCD converter (shift-add-3).
// Ports: clk, rstN (async, active-high), start, binary_value[25:0] in;
//        ready, done (1-cycle pulse), BCD_value[7:0] (4-bit digits) out.
module binary_to_bcd (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic [25:0] binary_value,
  output logic        ready,
  output logic        done,
  output logic [3:0]  BCD_value [7:0]
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD3  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [25:0] bin_q, bin_d;
  logic [31:0] scr_q, scr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] bcd_q, bcd_d;
  logic        done_q, done_d;

  // done is registered out of DONE, so the cycle it is high the FSM
  // already sits in IDLE; holding off acceptance for that one cycle
  // keeps ready and done mutually exclusive.
  logic accept;
  assign accept = (state_q == IDLE) && !done_q && start;

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ADD3;
      ADD3:    state_d = SHIFT;
      SHIFT:   state_d = (cnt_q == 5'd1) ? DONE : ADD3;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bin_d  = bin_q;
    scr_d  = scr_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bin_d = binary_value;
          scr_d = '0;
          cnt_d = 5'd26;
        end
      end
      ADD3: begin
        for (int i = 0; i < 8; i++) begin
          if (scr_q[4*i +: 4] >= 4'd5)
            scr_d[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
      end
      SHIFT: begin
        {scr_d, bin_d} = {scr_q, bin_q} << 1;
        cnt_d = cnt_q - 5'd1;
      end
      DONE: begin
        bcd_d  = scr_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      bin_q  <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      scr_q  <= scr_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    ready = (state_q == IDLE) && !done_q;
    done  = done_q;
    for (int i = 0; i < 8; i++) begin
      BCD_value[i] = bcd_q[4*i +: 4];
    end
  end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd.
// Random and directed values against a decimal reference model.
module tb_binary_to_bcd;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [25:0] binary_value;
  logic        ready;
  logic        done;
  logic [3:0]  BCD_value [7:0];

  int checks;
  int failures;
  logic [31:0] last_exp;

  binary_to_bcd dut (
    .clk          (clk),
    .rstN         (rstN),
    .start        (start),
    .binary_value (binary_value),
    .ready        (ready),
    .done         (done),
    .BCD_value    (BCD_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] dut_bcd();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = BCD_value[i];
    return r;
  endfunction

  // hold=1 keeps start high and scrambles binary_value while busy
  task automatic convert(input logic [25:0] v, input bit hold);
    int n;
    check("ready_before", {31'd0, ready}, 32'd1);
    start = 1'b1;
    binary_value = v;
    @(posedge clk); #1;
    check("ready_busy", {31'd0, ready}, 32'd0);
    if (!hold) start = 1'b0;
    n = 0;
    do begin
      if (hold) binary_value = 26'($urandom);
      @(posedge clk); #1;
      n++;
      if (n == 30) check("bcd_hold", dut_bcd(), last_exp);
    end while (!done && n < 100);
    check("latency", n, 53);
    check("result", dut_bcd(), ref_bcd(int'(v)));
    check("ready_done_excl", {31'd0, ready}, 32'd0);
    last_exp = ref_bcd(int'(v));
    @(posedge clk); #1;
    check("done_width", {31'd0, done}, 32'd0);
    check("ready_back", {31'd0, ready}, 32'd1);
    check("result_hold", dut_bcd(), last_exp);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_exp = '0;
    rstN = 1'b1;
    start = 1'b0;
    binary_value = '0;
    #3;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", dut_bcd(), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b0;
    @(posedge clk); #1;

    convert(26'd162, 1'b0);
    convert(26'd43210, 1'b0);
    convert(26'd0, 1'b0);
    convert(26'd67108863, 1'b0);

    // back-to-back: start stays high, next value accepted right after
    convert(26'd5555555, 1'b1);
    binary_value = 26'd12345678;
    convert(26'd12345678, 1'b0);

    // reset in the middle of a conversion
    start = 1'b1;
    binary_value = 26'd999999;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rstN = 1'b1;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_bcd", dut_bcd(), 32'd0);
    last_exp = '0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) check("midrst_nodone", {31'd0, done}, 32'd0);
    end
    check("midrst_bcd_after", dut_bcd(), 32'd0);
    rstN = 1'b0;
    @(posedge clk); #1;

    convert(26'd987654, 1'b0);

    for (int k = 0; k < 10; k++) begin
      convert(26'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
